// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the alu and its command front-end.
package alu_pkg;

  localparam int OPW = 5;

  // Status bit positions in {CF, ZF, NF, VF, PF, AF}
  localparam int CF_BIT = 5;
  localparam int ZF_BIT = 4;
  localparam int NF_BIT = 3;
  localparam int VF_BIT = 2;
  localparam int PF_BIT = 1;
  localparam int AF_BIT = 0;

  localparam logic [OPW-1:0] OP_ADD  = 5'd0;
  localparam logic [OPW-1:0] OP_ADC  = 5'd1;
  localparam logic [OPW-1:0] OP_SUB  = 5'd2;
  localparam logic [OPW-1:0] OP_SBC  = 5'd3;
  localparam logic [OPW-1:0] OP_INC  = 5'd4;
  localparam logic [OPW-1:0] OP_DEC  = 5'd5;
  localparam logic [OPW-1:0] OP_AND  = 5'd6;
  localparam logic [OPW-1:0] OP_OR   = 5'd7;
  localparam logic [OPW-1:0] OP_XOR  = 5'd8;
  localparam logic [OPW-1:0] OP_NOT  = 5'd9;
  localparam logic [OPW-1:0] OP_PASA = 5'd10;
  localparam logic [OPW-1:0] OP_PASB = 5'd11;
  localparam logic [OPW-1:0] OP_SHL  = 5'd12;
  localparam logic [OPW-1:0] OP_SHR  = 5'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational W-bit alu with {CF, ZF, NF, VF, PF, AF} status.
module alu
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [OPW-1:0] F,
  input  logic           Cin,
  output logic [W-1:0]   Result,
  output logic [5:0]     Status
);

  logic [W-1:0] b_eff;
  logic         c_in;
  logic         arith;
  logic [W:0]   sum;
  logic [W-1:0] res;
  logic         cf;
  logic         vf;
  logic         af;

  // Every arithmetic op is A + b_eff + c_in; subtraction uses carry (not borrow) sense
  always_comb begin
    b_eff = B;
    c_in  = 1'b0;
    arith = 1'b1;
    case (F)
      OP_ADD:  begin b_eff = B;       c_in = 1'b0; end
      OP_ADC:  begin b_eff = B;       c_in = Cin;  end
      OP_SUB:  begin b_eff = ~B;      c_in = 1'b1; end
      OP_SBC:  begin b_eff = ~B;      c_in = Cin;  end
      OP_INC:  begin b_eff = '0;      c_in = 1'b1; end
      OP_DEC:  begin b_eff = '1;      c_in = 1'b0; end
      default: arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, c_in};

  always_comb begin
    res = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    af  = 1'b0;
    if (arith) begin
      res = sum[W-1:0];
      cf  = sum[W];
      vf  = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]);
      af  = A[4] ^ b_eff[4] ^ sum[4];
    end else begin
      case (F)
        OP_AND:  res = A & B;
        OP_OR:   res = A | B;
        OP_XOR:  res = A ^ B;
        OP_NOT:  res = ~A;
        OP_PASA: res = A;
        OP_PASB: res = B;
        OP_SHL:  begin res = {A[W-2:0], 1'b0}; cf = A[W-1]; end
        OP_SHR:  begin res = {1'b0, A[W-1:1]}; cf = A[0];   end
        default: res = '0;
      endcase
    end
  end

  assign Result = res;

  always_comb begin
    Status         = '0;
    Status[CF_BIT] = cf;
    Status[ZF_BIT] = (res == '0);
    Status[NF_BIT] = res[W-1];
    Status[VF_BIT] = vf;
    Status[PF_BIT] = ~^res[7:0];
    Status[AF_BIT] = af;
  end

endmodule

// File: rtl/alu_op_ctrl.sv
// rtl/alu_op_ctrl.sv - register file and IDLE/EXEC/RESP command sequencer around alu.
module alu_op_ctrl
  import alu_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int NREG = 4,
  localparam int RA   = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [RA-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [RA-1:0]  cmd_srca,
  input  logic [RA-1:0]  cmd_srcb,
  input  logic [RA-1:0]  cmd_dst,
  input  logic           cmd_use_cf,
  input  logic           cmd_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic [5:0]     rsp_status,
  output logic [RA-1:0]  rsp_dst,
  output logic [5:0]     flags
);

  state_t         state;
  state_t         state_n;
  logic [W-1:0]   rf [NREG];
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [OPW-1:0] opf;
  logic           opc;
  logic [RA-1:0]  dst_q;
  logic [W-1:0]   alu_result;
  logic [5:0]     alu_status;

  alu #(.W(W)) u_alu (
    .A      (opa),
    .B      (opb),
    .F      (opf),
    .Cin    (opc),
    .Result (alu_result),
    .Status (alu_status)
  );

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Writeback is the later assignment so it overrides a same-address host write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (wr_en) rf[wr_addr] <= wr_data;
      if (state == EXEC) rf[dst_q] <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa        <= '0;
      opb        <= '0;
      opf        <= '0;
      opc        <= 1'b0;
      dst_q      <= '0;
      flags      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_dst    <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        opa   <= rf[cmd_srca];
        opb   <= rf[cmd_srcb];
        opf   <= cmd_op;
        opc   <= cmd_use_cf ? flags[CF_BIT] : cmd_cin;
        dst_q <= cmd_dst;
      end
      if (state == EXEC) begin
        flags      <= alu_status;
        rsp_result <= alu_result;
        rsp_status <= alu_status;
        rsp_dst    <= dst_q;
        rsp_valid  <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_op_ctrl.md
# alu_op_ctrl

Sequential command front-end for the 16-bit combinational `alu`. It holds a small operand register file and accepts ALU commands over a valid/ready handshake. It drives the ALU's `A`/`B`/`F`/`Cin` from registered operands and captures `Result`/`Status` into the destination register and a flags register. Completions are returned over a second valid/ready handshake. It sits directly upstream of `alu`, with `alu` instantiated as its sole sub-module.

## Interface
Parameters:
- `W`, 16: datapath width. Must match `alu`.
- `NREG`, 4: register file depth. Register addresses are `$clog2(NREG)` bits wide, called `RA` below.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host register write strobe.
- `wr_addr`  in  RA  host write address.
- `wr_data`  in  W  host write data.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  5  ALU opcode, passed unchanged to `F`.
- `cmd_srca`  in  RA  source register for `A`.
- `cmd_srcb`  in  RA  source register for `B`.
- `cmd_dst`  in  RA  destination register.
- `cmd_use_cf`  in  1  1: `Cin` comes from the stored CF; 0: `Cin` comes from `cmd_cin`.
- `cmd_cin`  in  1  explicit carry-in.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  W  captured `Result`.
- `rsp_status`  out  6  captured `Status` as {CF, ZF, NF, VF, PF, AF}.
- `rsp_dst`  out  RA  destination register of the completed command.
- `flags`  out  6  last captured `Status`.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- `cmd_ready` is 1 only in IDLE.
- **IDLE:** when `cmd_valid` is 1, the command is accepted. At that edge:
  - `opA` ← `rf[srca]`; `opB` ← `rf[srcb]`; `opF` ← `cmd_op`.
  - `opC` ← (`cmd_use_cf` ? `flags[5]` : `cmd_cin`).
  - `cmd_dst` is latched.
  - The state moves to EXEC.
- Operand reads see register contents from before the edge. A `wr_en` on the acceptance edge is not bypassed.
- **EXEC:** lasts exactly one cycle. The ALU is fed from `opA`/`opB`/`opF`/`opC`. At the end of EXEC:
  - `rf[dst]` ← `Result`.
  - `flags` ← `Status`.
  - `rsp_result`, `rsp_status` and `rsp_dst` are loaded.
  - The state moves to RESP.
- **RESP:** `rsp_valid` is 1. The `rsp_*` outputs stay stable until `rsp_ready` is 1. The state then moves to IDLE.
- **Write collision:** if a host `wr_en` and the EXEC writeback target the same address on the same edge, the EXEC writeback wins. A `wr_en` to any other address always completes.
- Host writes are accepted in every state.
- **Carry chaining:** a `cmd_use_cf` command takes the CF from the previous completed command. Multi-word add/subtract is therefore issued as back-to-back commands.
- **Reset:** reset in any state does the following:
  - state → IDLE, and any in-flight command is discarded with no response.
  - all `rf` entries, `flags`, `opA`/`opB`/`opF`/`opC` and the `rsp_*` outputs are cleared to 0.
  - `rsp_valid` = 0 and `cmd_ready` = 1 from the first cycle after the reset edge.
- Widths are fixed: `A`, `B` and `Result` are `W` bits; `Status` is 6 bits. There is no sign or zero extension anywhere.

## Timing
- Command accepted at edge k → EXEC during cycle k..k+1 → `rsp_valid` = 1 after edge k+1.
- `rsp_valid` is 1 no later than one cycle after acceptance.
- With `rsp_ready` tied to 1, throughput is one command per 3 cycles (IDLE, EXEC, RESP).
- All outputs are registered, except `cmd_ready`, which is decoded directly from the state register.
- The ALU path inside EXEC is single-cycle. There is no multicycle path.

## Structure
- Shared package `alu_pkg` holds:
  - the status bit index constants: `CF_BIT` = 5, `ZF_BIT` = 4, `NF_BIT` = 3, `VF_BIT` = 2, `PF_BIT` = 1, `AF_BIT` = 0;
  - the FSM state enum {IDLE, EXEC, RESP};
  - the opcode width constant (5).
- One sub-module, `alu`, instantiated unchanged. The register file and FSM are written inline.

## Test plan
- **Basic op:** write `rf[0]` = 16'h1234 and `rf[1]` = 16'h0F0F, then issue op X with srca=0, srcb=1, dst=2, `cmd_use_cf`=0, `cmd_cin`=0.
  - `rsp_valid` goes high 1 cycle after acceptance.
  - `rsp_result` and `rsp_status` equal the standalone `alu` outputs for the same inputs.
  - `rf[2]` holds `rsp_result`.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles.
  - `rsp_*` stays stable.
  - `cmd_ready` stays 0, and a `cmd_valid` presented during this time is not consumed.
  - Raising `rsp_ready` gives IDLE on the next cycle.
- **Carry chain:** `rf[0]` = 16'hFFFF, `rf[1]` = 16'h0001; issue an add-with-carry op, then a second op with `cmd_use_cf`=1.
  - The second command drives `Cin` = CF from the first command.
  - `flags[5]` matches the first `rsp_status[5]`.
- **Write collision:** host `wr_en` to `dst`=2 with 16'hDEAD on the EXEC-end edge.
  - `rf[2]` equals the ALU result, not 16'hDEAD.
  - A simultaneous write to address 3 lands.
- **Reset mid-EXEC:** assert `rst` in EXEC.
  - No `rsp_valid` ever appears.
  - All `rf` entries read 0, `flags` = 0, and `cmd_ready` = 1 the next cycle.
- **Random regression:** 10000 random commands against a reference model of `rf`, flags and `alu`; every response and `rf` entry must match.
